// File: rtl/ecp5pll_pkg.sv
// Shared definitions for the ECP5 PLL dynamic-phase controller.
//   pll_phase_state_e : 3-bit FSM state encoding
//   PhaseSel*         : phasesel codes selecting which PLL output is shifted
//   max_u             : elaboration-time helper used to size the timing counter
package ecp5pll_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSetup  = 3'd1,
    StPulse  = 3'd2,
    StGap    = 3'd3,
    StSettle = 3'd4,
    StDone   = 3'd5
  } pll_phase_state_e;

  localparam logic [1:0] PhaseSelClkos  = 2'd0;
  localparam logic [1:0] PhaseSelClkos2 = 2'd1;
  localparam logic [1:0] PhaseSelClkos3 = 2'd2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ecp5pll_phase_ctrl.sv
// Sequencer for the ECP5 PLL dynamic phase-shift pins.
// Accepts a request (output select, direction, pulse count) and emits that many
// phasestep pulses with programmable setup, pulse width and gap timing.
//
// Optional feature: define ECP5PLL_PHASE_LOCKWAIT_EN to add a SETTLE phase after
// the last pulse that waits for SETTLE_CYC consecutive cycles of locked=1.
//
// Ports:
//   clk_i, reset           : clock, synchronous active-high reset
//   req_valid/req_ready    : request handshake (ready only in IDLE with PLL locked)
//   req_sel/req_dir/steps  : phasesel code, direction (1 = advance), pulse count
//   locked                 : PLL lock indication
//   phasesel/phasedir/phasestep/phaseloadreg : PLL dynamic-phase pins
//   busy, done, steps_left : status
module ecp5pll_phase_ctrl
  import ecp5pll_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 4,
  parameter int unsigned PULSE_CYC  = 4,
  parameter int unsigned GAP_CYC    = 4,
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic       clk_i,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  input  logic       req_dir,
  input  logic [7:0] req_steps,
  input  logic       locked,
  output logic [1:0] phasesel,
  output logic       phasedir,
  output logic       phasestep,
  output logic       phaseloadreg,
  output logic       busy,
  output logic       done,
  output logic [7:0] steps_left
);

`ifdef ECP5PLL_PHASE_LOCKWAIT_EN
  localparam int unsigned MaxCyc = max_u(max_u(SETUP_CYC, PULSE_CYC), max_u(GAP_CYC, SETTLE_CYC));
`else
  localparam int unsigned MaxCyc = max_u(max_u(SETUP_CYC, PULSE_CYC), GAP_CYC);
`endif
  // Timer is loaded with N-1 and counts down to 0, so it only needs to hold MaxCyc-1.
  localparam int unsigned TimerW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [TimerW-1:0] SetupLd  = TimerW'(SETUP_CYC - 1);
  localparam logic [TimerW-1:0] PulseLd  = TimerW'(PULSE_CYC - 1);
  localparam logic [TimerW-1:0] GapLd    = TimerW'(GAP_CYC - 1);
`ifdef ECP5PLL_PHASE_LOCKWAIT_EN
  localparam logic [TimerW-1:0] SettleLd = TimerW'(SETTLE_CYC - 1);
`endif

  pll_phase_state_e  state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [7:0]        steps_q, steps_d;
  logic [1:0]        sel_q, sel_d;
  logic              dir_q, dir_d;

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q <= StIdle;
      timer_q <= '0;
      steps_q <= '0;
      sel_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      steps_q <= steps_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    steps_d = steps_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid && locked) begin
          sel_d   = req_sel;
          dir_d   = req_dir;
          steps_d = req_steps;
          timer_d = SetupLd;
          state_d = (req_steps == 8'd0) ? StDone : StSetup;
        end
      end
      StSetup: begin
        if (timer_q == '0) begin
          timer_d = PulseLd;
          state_d = StPulse;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      StPulse: begin
        if (timer_q == '0) begin
          steps_d = steps_q - 8'd1;
          if (steps_q != 8'd1) begin
            timer_d = GapLd;
            state_d = StGap;
          end else begin
`ifdef ECP5PLL_PHASE_LOCKWAIT_EN
            timer_d = SettleLd;
            state_d = StSettle;
`else
            state_d = StDone;
`endif
          end
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      StGap: begin
        if (timer_q == '0) begin
          timer_d = PulseLd;
          state_d = StPulse;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
`ifdef ECP5PLL_PHASE_LOCKWAIT_EN
      StSettle: begin
        // Any unlocked cycle restarts the consecutive-lock count.
        if (!locked) begin
          timer_d = SettleLd;
        end else if (timer_q == '0) begin
          state_d = StDone;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
`endif
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign req_ready    = (state_q == StIdle) && locked;
  assign busy         = (state_q != StIdle);
  assign phasestep    = (state_q == StPulse);
  assign phaseloadreg = 1'b0;
  assign phasesel     = sel_q;
  assign phasedir     = dir_q;
  assign steps_left   = steps_q;

endmodule
